key_bounce_gen: RTL and testbench

//  Stimulus-side counterpart of the key debounce/edge-detect path: turns a

---
 rtl/key_bounce_gen_pkg.sv | 25 ++
 rtl/key_bounce_gen_bounce_lfsr.sv | 33 +++
 rtl/key_bounce_gen.sv | 161 ++++++++++++++++
 tb/tb_key_bounce_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_bounce_gen_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | key_bounce_gen_pkg                                                        |
// | Shared definitions for the bouncy key stimulus generator: FSM states,    |
// | LFSR feedback taps, default seed and the LFSR step function.             |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package key_bounce_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_SETTLE = 2'd2
  } kb_state_t;

  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
  localparam logic [15:0] c_lfsr_taps         = 16'hB400;
  localparam logic [15:0] c_lfsr_seed_default = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {1'b0, q[15:1]} ^ (q[0] ? c_lfsr_taps : 16'h0000);
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_bounce_gen_bounce_lfsr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bounce_lfsr                                                               |
// | Free-running 16-bit Galois LFSR supplying bounce run lengths.            |
// | Ports: CLK  - clock                                                       |
// |        RSTn - asynchronous active-low reset (loads LFSR_SEED)            |
// |        q    - current LFSR state                                         |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module bounce_lfsr
  import key_bounce_gen_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = c_lfsr_seed_default
) (
  input  logic        CLK,
  input  logic        RSTn,
  output logic [15:0] q
);

  logic [15:0] r_state;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= LFSR_SEED;
    end else begin
      r_state <= lfsr_step(r_state);
    end
  end

  assign q = r_state;

endmodule
`default_nettype wire

// File: rtl/key_bounce_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | key_bounce_gen                                                            |
// | Turns clean press/release commands into a bouncy active-low key pin.     |
// | After an accepted level change the pin bounces for BOUNCE_LEN cycles     |
// | (LFSR-driven run lengths), then holds the target for SETTLE_LEN cycles.  |
// | Ports: CLK       - clock                                                 |
// |        RSTn      - asynchronous active-low reset                         |
// |        Req_Valid - command valid, held until accepted                    |
// |        Req_Press - 1 = press (pin low), 0 = release (pin high)           |
// |        Req_Ready - high in IDLE                                          |
// |        Pin_Out   - emulated key pin (registered)                         |
// |        Busy      - high while bouncing or settling                       |
// |        Done_Sig  - one-cycle completion pulse                            |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module key_bounce_gen
  import key_bounce_gen_pkg::*;
#(
  parameter int          BOUNCE_LEN = 1000,
  parameter int          SETTLE_LEN = 2000,
  parameter int          GLITCH_MAX = 15,
  parameter logic [15:0] LFSR_SEED  = c_lfsr_seed_default,
  parameter int          CNT_W      = 16
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic Req_Valid,
  input  logic Req_Press,
  output logic Req_Ready,
  output logic Pin_Out,
  output logic Busy,
  output logic Done_Sig
);

  // Terminal counts; the "-1" wraps harmlessly when a length is zero because
  // that phase is skipped entirely and the compare is never reached.
  localparam logic [CNT_W-1:0] c_bounce_last = CNT_W'(BOUNCE_LEN - 1);
  localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_LEN - 1);
  localparam logic [3:0]       c_run_mask    = 4'(GLITCH_MAX);
  localparam bit               c_has_bounce  = (BOUNCE_LEN > 0);
  localparam bit               c_has_settle  = (SETTLE_LEN > 0);

  kb_state_t        r_state,     w_state_nxt;
  logic [CNT_W-1:0] r_phase_cnt, w_phase_cnt_nxt;
  logic [3:0]       r_run_cnt,   w_run_cnt_nxt;
  logic             r_pin,       w_pin_nxt;
  logic             r_target,    w_target_nxt;
  logic             r_done,      w_done_nxt;

  logic [3:0]       w_lfsr_nib;
  logic [11:0]      w_lfsr_unused;
  logic [3:0]       w_run_load;
  logic             w_req_target;

  bounce_lfsr #(
    .LFSR_SEED (LFSR_SEED)
  ) u_lfsr (
    .CLK  (CLK),
    .RSTn (RSTn),
    .q    ({w_lfsr_unused, w_lfsr_nib})
  );

  // Run counter holds (remaining cycles - 1) of the current bounce run.
  assign w_run_load   = w_lfsr_nib & c_run_mask;
  assign w_req_target = ~Req_Press;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state     <= ST_IDLE;
      r_phase_cnt <= '0;
      r_run_cnt   <= '0;
      r_pin       <= 1'b1;
      r_target    <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase_cnt <= w_phase_cnt_nxt;
      r_run_cnt   <= w_run_cnt_nxt;
      r_pin       <= w_pin_nxt;
      r_target    <= w_target_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_phase_cnt_nxt = r_phase_cnt;
    w_run_cnt_nxt   = r_run_cnt;
    w_pin_nxt       = r_pin;
    w_target_nxt    = r_target;
    w_done_nxt      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (Req_Valid) begin
          w_target_nxt = w_req_target;
          if (w_req_target == r_pin) begin
            // Already at the requested level: complete immediately.
            w_done_nxt = 1'b1;
          end else begin
            // First bounce run starts at the target level.
            w_pin_nxt       = w_req_target;
            w_phase_cnt_nxt = '0;
            w_run_cnt_nxt   = w_run_load;
            if (c_has_bounce) begin
              w_state_nxt = ST_BOUNCE;
            end else if (c_has_settle) begin
              w_state_nxt = ST_SETTLE;
            end else begin
              w_done_nxt = 1'b1;
            end
          end
        end
      end

      ST_BOUNCE: begin
        if (r_phase_cnt == c_bounce_last) begin
          // Truncate whatever run is in progress and force the target.
          w_pin_nxt       = r_target;
          w_phase_cnt_nxt = '0;
          if (c_has_settle) begin
            w_state_nxt = ST_SETTLE;
          end else begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_phase_cnt_nxt = r_phase_cnt + CNT_W'(1);
          if (r_run_cnt == 4'd0) begin
            w_pin_nxt     = ~r_pin;
            w_run_cnt_nxt = w_run_load;
          end else begin
            w_run_cnt_nxt = r_run_cnt - 4'd1;
          end
        end
      end

      ST_SETTLE: begin
        if (r_phase_cnt == c_settle_last) begin
          w_state_nxt     = ST_IDLE;
          w_phase_cnt_nxt = '0;
          w_done_nxt      = 1'b1;
        end else begin
          w_phase_cnt_nxt = r_phase_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign Req_Ready = (r_state == ST_IDLE);
  assign Busy      = (r_state != ST_IDLE);
  assign Pin_Out   = r_pin;
  assign Done_Sig  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_key_bounce_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_key_bounce_gen                                                         |
// | Self-checking bench for key_bounce_gen with a waveform reference model.  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_key_bounce_gen;

  localparam int          B    = 20;
  localparam int          S    = 10;
  localparam int          G    = 3;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          DB_N = 8;

  logic CLK       = 1'b0;
  logic RSTn      = 1'b0;
  logic Req_Valid = 1'b0;
  logic Req_Press = 1'b0;
  logic Req_Ready, Pin_Out, Busy, Done_Sig;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] m_lfsr;
  logic        m_pin = 1'b1;

  always #5 CLK = ~CLK;

  key_bounce_gen #(
    .BOUNCE_LEN (B),
    .SETTLE_LEN (S),
    .GLITCH_MAX (G),
    .LFSR_SEED  (SEED),
    .CNT_W      (16)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .Req_Valid (Req_Valid),
    .Req_Press (Req_Press),
    .Req_Ready (Req_Ready),
    .Pin_Out   (Pin_Out),
    .Busy      (Busy),
    .Done_Sig  (Done_Sig)
  );

  // Polynomial x^16+x^14+x^13+x^11+1: exponent e maps to feedback bit e-1.
  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    logic [15:0] taps;
    taps     = 16'h0000;
    taps[15] = 1'b1;
    taps[13] = 1'b1;
    taps[12] = 1'b1;
    taps[10] = 1'b1;
    return (s >> 1) ^ (s[0] ? taps : 16'h0000);
  endfunction

  // Reference LFSR: value during a cycle is readable at that cycle's negedge.
  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) m_lfsr <= SEED;
    else       m_lfsr <= lfsr_adv(m_lfsr);
  end

  // Simple counting debouncer fed by the emulated pin.
  logic db_en = 1'b0;
  logic db_stable;
  int   db_cnt, db_h2l, db_l2h;
  always @(posedge CLK) begin
    if (!db_en) begin
      db_stable <= 1'b1;
      db_cnt    <= 0;
      db_h2l    <= 0;
      db_l2h    <= 0;
    end else if (Pin_Out === db_stable) begin
      db_cnt <= 0;
    end else if (db_cnt == DB_N - 1) begin
      db_stable <= Pin_Out;
      db_cnt    <= 0;
      if (db_stable) db_h2l <= db_h2l + 1;
      else           db_l2h <= db_l2h + 1;
    end else begin
      db_cnt <= db_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
  endtask

  // Issue one command and check every cycle up to and including Done_Sig.
  // hold_next keeps Req_Valid high (Req_Press toggling) through the busy
  // period and presents next_press on the completion cycle; pre_driven means
  // the request is already on the bus at the current negedge.
  task automatic do_cmd(input logic press, input bit hold_next,
                        input logic next_press, input bit pre_driven);
    logic        tgt, noop, lvl, prev;
    logic [15:0] s;
    int          total, pos, len, run, max_run, glitches;
    logic        wave [1:64];
    prev = 1'b0;
    if (!pre_driven) begin
      @(negedge CLK);
      Req_Valid = 1'b1;
      Req_Press = press;
    end
    chk("ready_at_accept", Req_Ready, 1'b1);
    tgt  = ~press;
    noop = (tgt == m_pin);
    if (noop) begin
      total   = 1;
      wave[1] = m_pin;
    end else begin
      total = B + S + 1;
      s     = m_lfsr;
      pos   = 1;
      lvl   = tgt;
      while (pos <= B) begin
        len = int'(s[3:0] & 4'(G)) + 1;
        for (int j = 0; j < len && pos <= B; j++) begin
          wave[pos] = lvl;
          pos++;
          s = lfsr_adv(s);
        end
        lvl = ~lvl;
      end
      for (int k = B + 1; k <= total; k++) wave[k] = tgt;
    end

    @(posedge CLK);
    #1;
    if (hold_next) Req_Press = 1'($urandom_range(0, 1));
    else           Req_Valid = 1'b0;

    max_run  = 0;
    run      = 0;
    glitches = 0;
    for (int k = 1; k <= total; k++) begin
      @(negedge CLK);
      chk("pin",   Pin_Out,   wave[k]);
      chk("busy",  Busy,      k < total);
      chk("done",  Done_Sig,  k == total);
      chk("ready", Req_Ready, k == total);
      if (!noop && k <= B) begin
        if (k > 1 && Pin_Out === prev) run++;
        else run = 1;
        prev = Pin_Out;
        if (run > max_run) max_run = run;
        if (k >= 2 && Pin_Out === ~tgt) glitches++;
      end
      if (hold_next) Req_Press = (k == total) ? next_press : 1'($urandom_range(0, 1));
    end
    if (!noop) begin
      chk("bounce_glitch_seen", glitches > 0, 1'b1);
      chk("bounce_max_run",     max_run <= G + 1, 1'b1);
    end
    m_pin = tgt;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic cur, nxt;
    bit   hold, pre;

    // Reset
    RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_pin",   Pin_Out,   1'b1);
    chk("reset_ready", Req_Ready, 1'b1);
    chk("reset_busy",  Busy,      1'b0);
    chk("reset_done",  Done_Sig,  1'b0);
    RSTn = 1'b1;
    @(negedge CLK);
    chk("idle_pin",  Pin_Out,  1'b1);
    chk("idle_done", Done_Sig, 1'b0);

    // First press, then press again while pressed (no-op)
    do_cmd(1'b1, 1'b0, 1'b0, 1'b0);
    do_cmd(1'b1, 1'b0, 1'b0, 1'b0);

    // Release with request held during busy; queued press taken on Done_Sig
    do_cmd(1'b0, 1'b1, 1'b1, 1'b0);
    do_cmd(1'b1, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a press bounce
    do_cmd(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    Req_Valid = 1'b1;
    Req_Press = 1'b1;
    @(posedge CLK);
    #1 Req_Valid = 1'b0;
    @(negedge CLK);
    chk("midrst_busy_before", Busy,    1'b1);
    chk("midrst_pin_before",  Pin_Out, 1'b0);
    #2 RSTn = 1'b0;
    #1;
    chk("midrst_pin",   Pin_Out,   1'b1);
    chk("midrst_busy",  Busy,      1'b0);
    chk("midrst_ready", Req_Ready, 1'b1);
    chk("midrst_done",  Done_Sig,  1'b0);
    m_pin = 1'b1;
    repeat (3) @(negedge CLK);
    RSTn = 1'b1;
    do_cmd(1'b1, 1'b0, 1'b0, 1'b0);

    // Randomized command stream with random gaps and queued requests
    pre = 1'b0;
    cur = 1'($urandom_range(0, 1));
    for (int i = 0; i < 14; i++) begin
      hold = (i < 13) && ($urandom_range(0, 1) == 1);
      nxt  = 1'($urandom_range(0, 1));
      if (!pre) repeat ($urandom_range(0, 4)) @(negedge CLK);
      do_cmd(cur, hold, nxt, pre);
      pre = hold;
      cur = nxt;
    end

    // Pin looped into a debouncer: one press/release, one edge each way
    do_cmd(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    db_en = 1'b1;
    @(negedge CLK);
    do_cmd(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge CLK);
    chk("debounce_pressed", db_stable, 1'b0);
    do_cmd(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge CLK);
    chk("debounce_h2l_once", db_h2l == 1, 1'b1);
    chk("debounce_l2h_once", db_l2h == 1, 1'b1);
    chk("debounce_released", db_stable, 1'b1);
    db_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
